decode_weight_update: RTL and testbench

Decode stage of the training datapath, directly downstream of the diff-to-decode pipeline register. Consumes dc_dw, the weight layer/row index, the update_weight flag, predict_value and z. For an update request it performs a read-modify-write of one weight row: w_new[i] = sat(w_old[i] - (dc_dw[i] >>> lr_shift)), one element per cycle. Requests without an update only forward predict_value and z to the next stage.

---
 rtl/decode_weight_update.sv | 212 +++++++++++++++++++++
 tb/tb_decode_weight_update.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_weight_update.sv
// decode_weight_update: decode stage of the training datapath.
// Forward-only requests register predict_value/z and pulse out_valid the next
// cycle. Update requests read one weight row, apply
// w_new[i] = sat(w_old[i] - (dc_dw[i] >>> lr_shift)) one element per cycle,
// then write the row back and pulse out_valid.
// Build option: define GRAD_CLIP_EN to clamp each gradient element to
// [-clip_limit, +clip_limit] before the learning-rate shift.
module decode_weight_update #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int lr_shift  = 4
`ifdef GRAD_CLIP_EN
    ,
    parameter int clip_limit = 'h0100
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [data_size*size-1:0]   predict_value,
    input  logic [data_size*size-1:0]   z,
    input  logic [data_size*size-1:0]   dc_dw,
    input  logic [31:0]                 w_layer_index,
    input  logic [31:0]                 w_row_index,
    input  logic                        update_weight,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    output logic [31:0]                 mem_layer_index,
    output logic [31:0]                 mem_row_index,
    input  logic [data_size*size-1:0]   mem_rd_data,
    output logic [data_size*size-1:0]   mem_wr_data,
    output logic [data_size*size-1:0]   predict_value_out,
    output logic [data_size*size-1:0]   z_out,
    output logic                        out_valid,
    output logic [15:0]                 update_count
);

    localparam int cnt_w = (size > 1) ? $clog2(size) : 1;
    localparam logic [cnt_w-1:0] last_idx = cnt_w'(size - 1);

    // Saturation bounds in the widened (data_size+1) difference domain
    localparam logic signed [data_size:0] sat_hi = {2'b00, {(data_size-1){1'b1}}};
    localparam logic signed [data_size:0] sat_lo = {2'b11, {(data_size-1){1'b0}}};
    localparam logic signed [data_size-1:0] max_val = {1'b0, {(data_size-1){1'b1}}};
    localparam logic signed [data_size-1:0] min_val = {1'b1, {(data_size-1){1'b0}}};

`ifdef GRAD_CLIP_EN
    localparam logic signed [data_size-1:0] clip_hi = data_size'(clip_limit);
    localparam logic signed [data_size-1:0] clip_lo = -clip_hi;
`endif

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        UPDATE,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic signed [data_size-1:0] dc_p0  [size];
    logic signed [data_size-1:0] row_p1 [size];
    logic [cnt_w-1:0]            elem_cnt;
    logic                        fwd_vld_p0;
    logic                        accept;
    logic signed [data_size-1:0] w_cur;
    logic signed [data_size-1:0] g_cur;

    // Learning-rate scaling of one gradient element (optionally clipped first)
    function automatic logic signed [data_size-1:0] scale_grad(
        input logic signed [data_size-1:0] d
    );
        logic signed [data_size-1:0] c;
`ifdef GRAD_CLIP_EN
        if (d > clip_hi) begin
            c = clip_hi;
        end else if (d < clip_lo) begin
            c = clip_lo;
        end else begin
            c = d;
        end
`else
        c = d;
`endif
        return c >>> lr_shift;
    endfunction

    // Subtract with one guard bit, then clamp back into data_size range
    function automatic logic signed [data_size-1:0] sat_sub(
        input logic signed [data_size-1:0] w,
        input logic signed [data_size-1:0] g
    );
        logic signed [data_size:0] diff;
        diff = {w[data_size-1], w} - {g[data_size-1], g};
        if (diff > sat_hi) begin
            sat_sub = max_val;
        end else if (diff < sat_lo) begin
            sat_sub = min_val;
        end else begin
            sat_sub = diff[data_size-1:0];
        end
    endfunction

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        out_valid = fwd_vld_p0;
        case (state)
            IDLE: begin
                if (accept && update_weight) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                mem_rd_en = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = UPDATE;
            end
            UPDATE: begin
                if (elem_cnt == last_idx) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                mem_wr_en = 1'b1;
                out_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands for the element currently being updated
    always_comb begin
        w_cur = row_p1[elem_cnt];
        g_cur = scale_grad(dc_p0[elem_cnt]);
    end

    // Request latch (p0), row buffer (p1), element counter and write counter
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_vld_p0        <= 1'b0;
            elem_cnt          <= '0;
            update_count      <= '0;
            predict_value_out <= '0;
            z_out             <= '0;
            mem_layer_index   <= '0;
            mem_row_index     <= '0;
            for (int i = 0; i < size; i++) begin
                dc_p0[i]  <= '0;
                row_p1[i] <= '0;
            end
        end else begin
            fwd_vld_p0 <= accept && !update_weight;
            if (accept) begin
                predict_value_out <= predict_value;
                z_out             <= z;
                mem_layer_index   <= w_layer_index;
                mem_row_index     <= w_row_index;
                for (int i = 0; i < size; i++) begin
                    dc_p0[i] <= dc_dw[i*data_size +: data_size];
                end
            end
            case (state)
                CAPTURE: begin
                    for (int i = 0; i < size; i++) begin
                        row_p1[i] <= mem_rd_data[i*data_size +: data_size];
                    end
                    elem_cnt <= '0;
                end
                UPDATE: begin
                    row_p1[elem_cnt] <= sat_sub(w_cur, g_cur);
                    elem_cnt         <= elem_cnt + cnt_w'(1);
                end
                WRITE: begin
                    update_count <= update_count + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Pack the row buffer onto the write-data bus
    always_comb begin
        mem_wr_data = '0;
        for (int i = 0; i < size; i++) begin
            mem_wr_data[i*data_size +: data_size] = row_p1[i];
        end
    end

endmodule

// File: tb/tb_decode_weight_update.sv
// Testbench for decode_weight_update: table vectors from the test plan,
// hand-written reset/backpressure sequences and randomized requests checked
// against an integer-arithmetic reference model and a bench-side weight RAM.
module tb_decode_weight_update;

    localparam int SZ   = 3;
    localparam int DW   = 16;
    localparam int VW   = SZ * DW;
    localparam int LR   = 4;
    localparam int CLIP = 256;
    localparam int UPD_LAT = 3 + SZ;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] predict_value;
    logic [VW-1:0] z;
    logic [VW-1:0] dc_dw;
    logic [31:0]   w_layer_index;
    logic [31:0]   w_row_index;
    logic          update_weight;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [31:0]   mem_layer_index;
    logic [31:0]   mem_row_index;
    logic [VW-1:0] mem_rd_data;
    logic [VW-1:0] mem_wr_data;
    logic [VW-1:0] predict_value_out;
    logic [VW-1:0] z_out;
    logic          out_valid;
    logic [15:0]   update_count;

    always #5 clk = ~clk;

    decode_weight_update #(
        .size      (SZ),
        .data_size (DW),
        .lr_shift  (LR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .predict_value     (predict_value),
        .z                 (z),
        .dc_dw             (dc_dw),
        .w_layer_index     (w_layer_index),
        .w_row_index       (w_row_index),
        .update_weight     (update_weight),
        .mem_rd_en         (mem_rd_en),
        .mem_wr_en         (mem_wr_en),
        .mem_layer_index   (mem_layer_index),
        .mem_row_index     (mem_row_index),
        .mem_rd_data       (mem_rd_data),
        .mem_wr_data       (mem_wr_data),
        .predict_value_out (predict_value_out),
        .z_out             (z_out),
        .out_valid         (out_valid),
        .update_count      (update_count)
    );

    // Weight RAM: 4 layers x 4 rows, one-cycle read latency
    logic [VW-1:0] ram [16];
    logic          pre_en = 1'b0;
    logic [3:0]    pre_idx = '0;
    logic [VW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[{mem_layer_index[1:0], mem_row_index[1:0]}];
        if (mem_wr_en) ram[{mem_layer_index[1:0], mem_row_index[1:0]}] <= mem_wr_data;
        if (pre_en) ram[pre_idx] <= pre_data;
    end

    // Event monitor, sampled mid-cycle
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc_cnt = 0, last_acc_cyc = 0;
    int rd_cnt = 0, last_rd_cyc = 0;
    int wr_cnt = 0, last_wr_cyc = 0;
    int ov_cnt = 0, last_ov_cyc = 0;
    int both_cnt = 0;
    logic [VW-1:0] last_wr_data = '0, last_ov_pv = '0, last_ov_z = '0;
    logic [3:0]    last_wr_idx = '0;

    always @(negedge clk) begin
        if (in_valid && in_ready) begin acc_cnt++; last_acc_cyc = cyc; end
        if (mem_rd_en) begin rd_cnt++; last_rd_cyc = cyc; end
        if (mem_wr_en) begin
            wr_cnt++; last_wr_cyc = cyc; last_wr_data = mem_wr_data;
            last_wr_idx = {mem_layer_index[1:0], mem_row_index[1:0]};
        end
        if (mem_rd_en && mem_wr_en) both_cnt++;
        if (out_valid) begin
            ov_cnt++; last_ov_cyc = cyc; last_ov_pv = predict_value_out; last_ov_z = z_out;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [VW-1:0] ref_mem [16];
    int exp_cnt = 0;

    // w - floor(d / 2^LR), clamped to the 16-bit signed range
    function automatic logic [VW-1:0] ref_update(input logic [VW-1:0] old_row, input logic [VW-1:0] dc);
        logic [VW-1:0] res;
        logic [15:0] tw, td;
        int w, d, g, r;
        res = '0;
        for (int i = 0; i < SZ; i++) begin
            tw = old_row[i*DW +: DW];
            td = dc[i*DW +: DW];
            w = $signed(tw);
            d = $signed(td);
`ifdef GRAD_CLIP_EN
            if (d > CLIP) d = CLIP;
            if (d < -CLIP) d = -CLIP;
`endif
            if (d >= 0) g = d / (1 << LR);
            else        g = -((-d + (1 << LR) - 1) / (1 << LR));
            r = w - g;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            res[i*DW +: DW] = r[15:0];
        end
        return res;
    endfunction

    task automatic preload(input logic [3:0] idx, input logic [VW-1:0] data);
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        step();
        pre_en = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic set_req(input logic upd, input logic [3:0] idx, input logic [VW-1:0] pv,
                           input logic [VW-1:0] zz, input logic [VW-1:0] dc);
        update_weight = upd;
        w_layer_index = {30'd0, idx[3:2]};
        w_row_index   = {30'd0, idx[1:0]};
        predict_value = pv;
        z             = zz;
        dc_dw         = dc;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin step(); n++; end
        chk({tag, "_ready"}, in_ready, 1);
    endtask

    task automatic run_req(input string tag, input logic upd, input logic [3:0] idx,
                           input logic [VW-1:0] pv, input logic [VW-1:0] zz,
                           input logic [VW-1:0] dc, output logic [VW-1:0] got_wr);
        int rd0, wr0, ov0, acc0;
        logic [VW-1:0] exp_row;
        rd0 = rd_cnt; wr0 = wr_cnt; ov0 = ov_cnt; acc0 = acc_cnt;
        set_req(upd, idx, pv, zz, dc);
        in_valid = 1'b1;
        wait_ready(tag);
        step();
        in_valid = 1'b0;
        chk({tag, "_accepted"}, acc_cnt - acc0, 1);
        if (upd) begin
            exp_row = ref_update(ref_mem[idx], dc);
            ref_mem[idx] = exp_row;
            exp_cnt++;
            repeat (8) step();
            chk({tag, "_rd_pulses"}, rd_cnt - rd0, 1);
            chk({tag, "_wr_pulses"}, wr_cnt - wr0, 1);
            chk({tag, "_rd_lat"}, last_rd_cyc - last_acc_cyc, 1);
            chk({tag, "_wr_lat"}, last_wr_cyc - last_acc_cyc, UPD_LAT);
            chk({tag, "_ov_lat"}, last_ov_cyc - last_acc_cyc, UPD_LAT);
            chk({tag, "_ov_pulses"}, ov_cnt - ov0, 1);
            chk({tag, "_wr_data"}, last_wr_data, exp_row);
            chk({tag, "_wr_addr"}, last_wr_idx, idx);
            chk({tag, "_count"}, update_count, exp_cnt & 'hFFFF);
            chk({tag, "_idle"}, in_ready, 1);
        end else begin
            repeat (2) step();
            chk({tag, "_ov_pulses"}, ov_cnt - ov0, 1);
            chk({tag, "_ov_lat"}, last_ov_cyc - last_acc_cyc, 1);
            chk({tag, "_pv_out"}, last_ov_pv, pv);
            chk({tag, "_z_out"}, last_ov_z, zz);
            chk({tag, "_no_rd"}, rd_cnt - rd0, 0);
            chk({tag, "_no_wr"}, wr_cnt - wr0, 0);
        end
        got_wr = last_wr_data;
    endtask

    function automatic logic [15:0] rand_elem();
        case ($urandom_range(0, 3))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'($urandom_range(0, 65535));
            default: return 16'($urandom_range(0, 63)) - 16'd32;
        endcase
    endfunction

    typedef struct {
        logic          upd;
        logic [3:0]    idx;
        logic [VW-1:0] old_row;
        logic [VW-1:0] pv;
        logic [VW-1:0] zz;
        logic [VW-1:0] dc;
        logic [VW-1:0] exp_row;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] got;
        logic [VW-1:0] row_a, row_b, exp_a, exp_b, dc_a, dc_b;
        logic [63:0]   r64;
        int wr0, ov0, acc_a, acc_b, wr_a, zeros;

        vecs[0] = '{1'b0, 4'd0, 48'h0, 48'h0300_0200_0100, 48'h0003_0002_0001, 48'h0, 48'h0};
        vecs[1] = '{1'b1, 4'd1, 48'hFF00_0200_0100, 48'h0011_0022_0033, 48'h0044_0055_0066,
                    48'h0000_FFF0_0010, 48'hFF00_0201_00FF};
        vecs[2] = '{1'b1, 4'd2, 48'h0000_7FFF_8001, 48'h1, 48'h2,
                    48'h0000_8000_7FF0, 48'h0000_7FFF_8000};
`ifdef GRAD_CLIP_EN
        vecs[3] = '{1'b1, 4'd3, 48'h0000_0000_0100, 48'h3, 48'h4,
                    48'h0000_0000_7FF0, 48'h0000_0000_00F0};
`else
        vecs[3] = '{1'b1, 4'd3, 48'h0000_0000_0100, 48'h3, 48'h4,
                    48'h0000_0000_7FF0, 48'h0000_0000_F901};
`endif
        vecs[4] = '{1'b1, 4'd4, 48'h0000_0000_0005, 48'h5, 48'h6,
                    48'h001F_FFEF_FFFF, 48'hFFFF_0002_0006};
        vecs[5] = '{1'b0, 4'd9, 48'h0, 48'hDEAD_BEEF_1234, 48'h8000_7FFF_0000, 48'h0, 48'h0};

        // Reset state, with a request pending that must not be taken
        reset = 1'b1; in_valid = 1'b1;
        set_req(1'b1, 4'd0, 48'h0, 48'h0, 48'h0);
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", update_count, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_no_accept", acc_cnt, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            r64 = {$urandom(), $urandom()};
            preload(4'(i), r64[VW-1:0]);
        end
        reset = 1'b0;
        step();
        chk("post_rst_ready", in_ready, 1);

        // Reset sampled at T4 while the row is being updated
        preload(4'd5, 48'h0001_0002_0003);
        set_req(1'b1, 4'd5, 48'hAAAA_BBBB_CCCC, 48'h1111_2222_3333, 48'h0010_0020_0030);
        in_valid = 1'b1;
        wait_ready("abort");
        step();
        in_valid = 1'b0;
        wr0 = wr_cnt; ov0 = ov_cnt;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("abort_wr_en", mem_wr_en, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_pv_out", predict_value_out, 0);
        chk("abort_z_out", z_out, 0);
        chk("abort_wr_data", mem_wr_data, 0);
        chk("abort_layer", mem_layer_index, 0);
        reset = 1'b0;
        exp_cnt = 0;
        step();
        chk("abort_ready_after", in_ready, 1);
        repeat (10) step();
        chk("abort_no_write", wr_cnt - wr0, 0);
        chk("abort_no_ov", ov_cnt - ov0, 0);
        chk("abort_count", update_count, 0);
        chk("abort_ram_kept", ram[5], 48'h0001_0002_0003);

        // Plan vectors
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].upd) preload(vecs[v].idx, vecs[v].old_row);
            run_req($sformatf("vec%0d", v), vecs[v].upd, vecs[v].idx, vecs[v].pv,
                    vecs[v].zz, vecs[v].dc, got);
            if (vecs[v].upd) chk($sformatf("vec%0d_table_row", v), got, vecs[v].exp_row);
        end

        // Back-to-back updates with in_valid held high throughout
        row_a = 48'h1000_2000_3000; row_b = 48'h8001_7FFF_0000;
        dc_a  = 48'h0100_FF00_0040; dc_b  = 48'h7FF0_8000_FFFF;
        preload(4'd6, row_a);
        preload(4'd7, row_b);
        exp_a = ref_update(row_a, dc_a);
        exp_b = ref_update(row_b, dc_b);
        set_req(1'b1, 4'd6, 48'h6, 48'h6, dc_a);
        in_valid = 1'b1;
        wait_ready("bp_a");
        step();
        acc_a = last_acc_cyc;
        set_req(1'b1, 4'd7, 48'h7, 48'h7, dc_b);
        zeros = 0;
        while (!in_ready && zeros < 20) begin zeros++; step(); end
        chk("bp_busy_cycles", zeros, 6);
        step();
        in_valid = 1'b0;
        acc_b = last_acc_cyc;
        wr_a  = last_wr_cyc;
        chk("bp_second_accept", acc_b - acc_a, 7);
        chk("bp_first_write", wr_a - acc_a, UPD_LAT);
        chk("bp_first_data", last_wr_data, exp_a);
        repeat (8) step();
        chk("bp_second_write", last_wr_cyc - acc_a, 13);
        chk("bp_second_data", last_wr_data, exp_b);
        ref_mem[6] = exp_a; ref_mem[7] = exp_b;
        exp_cnt += 2;
        chk("bp_count", update_count, exp_cnt & 'hFFFF);

        // Randomized requests against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [VW-1:0] pv, zz, dc;
            r64 = {$urandom(), $urandom()}; pv = r64[VW-1:0];
            r64 = {$urandom(), $urandom()}; zz = r64[VW-1:0];
            dc = {rand_elem(), rand_elem(), rand_elem()};
            run_req($sformatf("rnd%0d", n), ($urandom_range(0, 2) != 0),
                    4'($urandom_range(0, 15)), pv, zz, dc, got);
            repeat ($urandom_range(0, 2)) step();
        end

        chk("ram_matches_model_6", ram[6], ref_mem[6]);
        chk("strobes_never_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
